// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder: XADC DRP stand-in with a 128x16 register space, fixed-latency responses and threshold alarms
module xadc_drp_responder #(
    parameter int pLATENCY  = 4,
    parameter int pNUM_MEAS = 64
) (
    input  logic        clk_usb,
    input  logic        reset_i,
    input  logic [6:0]  daddr_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic        drdy_out,
    output logic [15:0] do_out,
    output logic        busy_out,
    output logic        drp_err_o,
    input  logic        meas_we,
    input  logic [5:0]  meas_addr,
    input  logic [15:0] meas_data,
    output logic        user_temp_alarm_out,
    output logic        vccint_alarm_out,
    output logic        vccaux_alarm_out,
    output logic        ot_out,
    output logic        vbram_alarm_out
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;
    logic [3:0]  cnt;
    logic [6:0]  addr_q;
    logic        we_q;
    logic [15:0] di_q, do_q;
    logic [15:0] regs [128];
    logic [11:0] t0, t1, t2, t6;
    logic        accept;

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE || cnt == 4'd0) ? (den_in ? WAIT : IDLE) : WAIT;
    end

    always_comb begin
        drdy_out = state == WAIT && cnt == 4'd0;
        busy_out = state == WAIT && cnt != 4'd0;
        do_out   = (drdy_out && !we_q) ? regs[addr_q] : do_q;
    end

    // A request arriving in the response cycle is accepted, not flagged.
    assign accept = den_in && !busy_out;

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            cnt       <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            di_q      <= '0;
            do_q      <= '0;
            drp_err_o <= 1'b0;
        end else begin
            if (accept) begin
                cnt    <= 4'(pLATENCY - 1);
                addr_q <= daddr_in;
                we_q   <= dwe_in;
                di_q   <= di_in;
            end else if (busy_out) begin
                cnt <= cnt - 4'd1;
            end
            if (drdy_out) do_q <= do_out;
            if (den_in && busy_out) drp_err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 128; i++) regs[i] <= '0;
        end else begin
            if (meas_we) regs[{1'b0, meas_addr}] <= meas_data;
            if (drdy_out && we_q && addr_q >= 7'(pNUM_MEAS)) regs[addr_q] <= di_q;
        end
    end

    assign t0 = regs[7'h00][15:4];
    assign t1 = regs[7'h01][15:4];
    assign t2 = regs[7'h02][15:4];
    assign t6 = regs[7'h06][15:4];

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            user_temp_alarm_out <= 1'b0;
            ot_out              <= 1'b0;
            vccint_alarm_out    <= 1'b0;
            vccaux_alarm_out    <= 1'b0;
            vbram_alarm_out     <= 1'b0;
        end else begin
            if (t0 > regs[7'h50][15:4])      user_temp_alarm_out <= 1'b1;
            else if (t0 < regs[7'h54][15:4]) user_temp_alarm_out <= 1'b0;
            if (t0 > regs[7'h53][15:4])      ot_out <= 1'b1;
            else if (t0 < regs[7'h57][15:4]) ot_out <= 1'b0;
            vccint_alarm_out <= t1 > regs[7'h51][15:4] || t1 < regs[7'h55][15:4];
            vccaux_alarm_out <= t2 > regs[7'h52][15:4] || t2 < regs[7'h56][15:4];
            vbram_alarm_out  <= t6 > regs[7'h58][15:4] || t6 < regs[7'h5C][15:4];
        end
    end
endmodule

// File: tb/tb_xadc_drp_responder.sv
// tb_xadc_drp_responder: directed DRP/backdoor stimulus checked every cycle against a transaction-level model
module tb_xadc_drp_responder;
    localparam int L = 4;
    logic        clk_usb = 1'b0;
    logic        reset_i;
    logic [6:0]  daddr_in = '0;
    logic        den_in = 1'b0, dwe_in = 1'b0;
    logic [15:0] di_in = '0;
    logic        meas_we = 1'b0;
    logic [5:0]  meas_addr = '0;
    logic [15:0] meas_data = '0;
    logic        drdy_out, busy_out, drp_err_o;
    logic [15:0] do_out;
    logic        user_temp_alarm_out, vccint_alarm_out, vccaux_alarm_out, ot_out, vbram_alarm_out;
    int errors = 0, checks = 0;

    xadc_drp_responder #(.pLATENCY(L), .pNUM_MEAS(64)) dut (
        .clk_usb(clk_usb), .reset_i(reset_i), .daddr_in(daddr_in), .den_in(den_in),
        .dwe_in(dwe_in), .di_in(di_in), .drdy_out(drdy_out), .do_out(do_out),
        .busy_out(busy_out), .drp_err_o(drp_err_o), .meas_we(meas_we),
        .meas_addr(meas_addr), .meas_data(meas_data),
        .user_temp_alarm_out(user_temp_alarm_out), .vccint_alarm_out(vccint_alarm_out),
        .vccaux_alarm_out(vccaux_alarm_out), .ot_out(ot_out), .vbram_alarm_out(vbram_alarm_out));

    always #5 clk_usb = ~clk_usb;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: register array plus one pending transaction with an absolute due cycle.
    logic [15:0] m_regs [128];
    int          cyc = 0, due = 0;
    bit          pend = 0, m_we = 0, m_err = 0, m_rdy, m_busy;
    logic [6:0]  m_addr = '0;
    logic [15:0] m_di = '0, m_do = '0;
    bit          m_temp = 0, m_ot = 0, m_vi = 0, m_va = 0, m_vb = 0;

    initial foreach (m_regs[i]) m_regs[i] = '0;

    function automatic logic [11:0] th(input int a);
        return m_regs[a][15:4];
    endfunction

    always @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            pend = 0; m_do = '0; m_err = 0;
            m_temp = 0; m_ot = 0; m_vi = 0; m_va = 0; m_vb = 0;
        end else begin
            m_rdy  = pend && due == cyc;
            m_busy = pend && due > cyc;
            m_temp = (th(0) > th('h50)) ? 1'b1 : (th(0) < th('h54)) ? 1'b0 : m_temp;
            m_ot   = (th(0) > th('h53)) ? 1'b1 : (th(0) < th('h57)) ? 1'b0 : m_ot;
            m_vi   = th(1) > th('h51) || th(1) < th('h55);
            m_va   = th(2) > th('h52) || th(2) < th('h56);
            m_vb   = th(6) > th('h58) || th(6) < th('h5C);
            if (m_rdy) begin
                pend = 0;
                if (!m_we) m_do = m_regs[m_addr];
                else if (m_addr >= 7'd64) m_regs[m_addr] = m_di;
            end
            if (den_in) begin
                if (m_busy) m_err = 1;
                else begin
                    pend = 1; due = cyc + L; m_addr = daddr_in; m_we = dwe_in; m_di = di_in;
                end
            end
            if (meas_we) m_regs[meas_addr] = meas_data;
        end
        if (!reset_i) cyc++;
    end

    always @(negedge clk_usb) begin
        bit e_rdy;
        e_rdy = pend && due == cyc;
        chk("drdy", 16'(drdy_out), 16'(e_rdy));
        chk("busy", 16'(busy_out), 16'(pend && due > cyc));
        chk("err", 16'(drp_err_o), 16'(m_err));
        chk("do", do_out, (e_rdy && !m_we) ? m_regs[m_addr] : m_do);
        chk("temp", 16'(user_temp_alarm_out), 16'(m_temp));
        chk("ot", 16'(ot_out), 16'(m_ot));
        chk("vccint", 16'(vccint_alarm_out), 16'(m_vi));
        chk("vccaux", 16'(vccaux_alarm_out), 16'(m_va));
        chk("vbram", 16'(vbram_alarm_out), 16'(m_vb));
    end

    task automatic tick;
        @(posedge clk_usb);
        #1;
    endtask

    task automatic bd(input logic [5:0] a, input logic [15:0] d);
        meas_we = 1'b1; meas_addr = a; meas_data = d;
        tick;
        meas_we = 1'b0;
    endtask

    task automatic drp(input bit we, input logic [6:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output int lat);
        bit got;
        den_in = 1'b1; dwe_in = we; daddr_in = a; di_in = d;
        tick;
        den_in = 1'b0; dwe_in = 1'b0;
        got = 0; lat = 0; rd = '0;
        while (!got && lat < 20) begin
            lat++;
            @(negedge clk_usb);
            if (drdy_out) begin
                got = 1; rd = do_out;
            end
            @(posedge clk_usb);
            #1;
        end
        if (!got) lat = -1;
    endtask

    initial begin
        logic [15:0] rd;
        int lat;
        reset_i = 1'b1;
        repeat (3) tick;
        chk("rst_do", do_out, 16'h0000);
        chk("rst_err", 16'(drp_err_o), 16'h0);
        reset_i = 1'b0;
        tick;
        bd(6'h03, 16'hABC0);
        tick;
        drp(0, 7'h03, '0, rd, lat);
        chk("rd_lat", 16'(lat), 16'd4);
        chk("rd_data", rd, 16'hABC0);
        drp(1, 7'h41, 16'h1234, rd, lat);
        chk("wr_lat", 16'(lat), 16'd4);
        chk("wr_do_hold", rd, 16'hABC0);
        drp(0, 7'h41, '0, rd, lat);
        chk("rb_41", rd, 16'h1234);
        bd(6'h05, 16'h0550);
        drp(1, 7'h05, 16'hFFFF, rd, lat);
        chk("ro_wr_lat", 16'(lat), 16'd4);
        drp(0, 7'h05, '0, rd, lat);
        chk("ro_05", rd, 16'h0550);
        // back-to-back: second request lands in the first one's response cycle
        den_in = 1'b1; daddr_in = 7'h41;
        tick;
        den_in = 1'b0;
        repeat (3) tick;
        den_in = 1'b1; daddr_in = 7'h03;
        tick;
        den_in = 1'b0;
        repeat (6) tick;
        chk("b2b_err", 16'(drp_err_o), 16'h0);
        den_in = 1'b1; daddr_in = 7'h03;
        tick;
        den_in = 1'b0;
        tick;
        den_in = 1'b1;
        tick;
        den_in = 1'b0;
        chk("ovl_err", 16'(drp_err_o), 16'h1);
        repeat (4) tick;
        chk("ovl_err_sticky", 16'(drp_err_o), 16'h1);
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        chk("ovl_err_rst", 16'(drp_err_o), 16'h0);
        tick;
        drp(1, 7'h50, 16'h8000, rd, lat);
        drp(1, 7'h54, 16'h7000, rd, lat);
        bd(6'h00, 16'h8010); tick; chk("temp_set", 16'(user_temp_alarm_out), 16'h1);
        bd(6'h00, 16'h7800); tick; chk("temp_hold1", 16'(user_temp_alarm_out), 16'h1);
        bd(6'h00, 16'h6FF0); tick; chk("temp_clr", 16'(user_temp_alarm_out), 16'h0);
        bd(6'h00, 16'h8000); tick; chk("temp_hold0", 16'(user_temp_alarm_out), 16'h0);
        drp(1, 7'h51, 16'h6000, rd, lat);
        drp(1, 7'h55, 16'h5000, rd, lat);
        bd(6'h01, 16'h5800); tick; chk("vi_in", 16'(vccint_alarm_out), 16'h0);
        bd(6'h01, 16'h4FF0); tick; chk("vi_lo", 16'(vccint_alarm_out), 16'h1);
        bd(6'h01, 16'h6010); tick; chk("vi_hi", 16'(vccint_alarm_out), 16'h1);
        bd(6'h01, 16'h5000); tick; chk("vi_eq", 16'(vccint_alarm_out), 16'h0);
        drp(1, 7'h52, 16'h9000, rd, lat);
        bd(6'h02, 16'h9100); tick; chk("va_hi", 16'(vccaux_alarm_out), 16'h1);
        bd(6'h06, 16'h0010); tick; chk("vb_hi", 16'(vbram_alarm_out), 16'h1);
        drp(1, 7'h41, 16'h1234, rd, lat);
        den_in = 1'b1; daddr_in = 7'h41; dwe_in = 1'b0;
        tick;
        den_in = 1'b0;
        tick;
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        repeat (6) tick;
        chk("mid_do", do_out, 16'h0000);
        chk("mid_alarms", 16'({user_temp_alarm_out, ot_out, vccint_alarm_out, vccaux_alarm_out, vbram_alarm_out}), 16'h0);
        drp(0, 7'h41, '0, rd, lat);
        chk("mid_rb_41", rd, 16'h0000);
        tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
